// File: rtl/adc8_conv_emulator_pkg.sv
// Shared definitions for the 8-bit converter emulator: FSM encodings and default timing.
package adc8_conv_emulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_SETUP   = 2'd2,
        ST_EOC_LOW = 2'd3
    } state_t;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CONV_CYCLES = 40;
    localparam int DEF_EOC_CYCLES  = 10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adc8_conv_emulator_sync_rise_detect.sv
// N-flop synchroniser for an asynchronous strobe with a single-cycle rising-edge pulse.
module sync_rise_detect #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // NOTE: flops use non-blocking assignments so every stage samples the pre-edge value of its neighbour.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/adc8_conv_emulator.sv
// Responder side of the CONVST/EOC handshake: samples a code on each CONVST edge and returns it
// after a fixed conversion time, followed by an active-low EOC pulse.
module adc8_conv_emulator
    import adc8_conv_emulator_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CONV_CYCLES = DEF_CONV_CYCLES,
    parameter int EOC_CYCLES  = DEF_EOC_CYCLES
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_convst,
    input  logic [DATA_W-1:0] i_sample,
    output logic [DATA_W-1:0] o_data,
    output logic              o_eoc,
    output logic              o_busy,
    output logic              o_overrun,
    output logic [7:0]        o_overrun_cnt
);

    localparam int CNT_W = $clog2(max_int(CONV_CYCLES, EOC_CYCLES) + 1);
    localparam logic [CNT_W-1:0] CONV_LOAD = CNT_W'(CONV_CYCLES - 1);
    localparam logic [CNT_W-1:0] EOC_LOAD  = CNT_W'(EOC_CYCLES - 1);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  hold;
    logic               edge_seen;
    logic               start;
    logic               reject;

    // Reset value 1: a CONVST already high when reset releases must not count as an edge.
    sync_rise_detect #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_convst_sync (
        .clk   (i_clk),
        .reset (i_reset),
        .din   (i_convst),
        .rise  (edge_seen)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_next = state;
        start      = 1'b0;
        reject     = edge_seen && (state != ST_IDLE);
        unique case (state)
            ST_IDLE: begin
                if (edge_seen && i_enable) begin
                    start      = 1'b1;
                    state_next = ST_CONVERT;
                end
            end
            ST_CONVERT: if (cnt == '0) state_next = ST_SETUP;
            ST_SETUP:   state_next = ST_EOC_LOW;
            ST_EOC_LOW: if (cnt == '0) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // NOTE: the hold register has no reset; it is always written at conversion start before o_data reads it.
    always_ff @(posedge i_clk) begin
        if (start) hold <= i_sample;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt           <= '0;
            o_data        <= '0;
            o_eoc         <= 1'b1;
            o_busy        <= 1'b0;
            o_overrun     <= 1'b0;
            o_overrun_cnt <= '0;
        end else begin
            // One shared down-counter times both the conversion and the EOC pulse.
            if (start)                 cnt <= CONV_LOAD;
            else if (state == ST_SETUP) cnt <= EOC_LOAD;
            else if (cnt != '0)        cnt <= cnt - 1'b1;

            if (state == ST_CONVERT && state_next == ST_SETUP) o_data <= hold;

            // Outputs are registered from the next state so they align with the state itself.
            o_busy    <= (state_next != ST_IDLE);
            o_eoc     <= (state_next != ST_EOC_LOW);
            o_overrun <= reject;
            if (reject && o_overrun_cnt != 8'hFF) o_overrun_cnt <= o_overrun_cnt + 8'd1;
        end
    end

endmodule
